// File: rtl/hzd_pkg.sv
// Shared types and defaults for the register hazard scoreboard.
// The entry rdy field is the cycles left before a result can be forwarded.
package hzd_pkg;
    localparam int REG_AW    = 5;
    localparam int DEPTH_DEF = 3;
    localparam int LAT_W_DEF = 2;

    typedef logic [LAT_W_DEF-1:0] lat_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        lat_t              rdy;
    } hzd_entry_t;
endpackage

// File: rtl/hzd_match.sv
// Priority match of one ID source against the in-flight write entries.
// Latency: combinational, zero cycles.
// Backpressure: none; not_rdy feeds the stall decision upstream.
module hzd_match
    import hzd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              src_use,
    input  logic [REG_AW-1:0] rs,
    input  hzd_entry_t        ent [DEPTH],
    output logic [DEPTH-1:0]  hzd,
    output logic              not_rdy
);

    always_comb begin
        logic found;
        found   = 1'b0;
        hzd     = '0;
        not_rdy = 1'b0;
        // Youngest producer wins; x0 is never tracked as a dependency.
        if (src_use && (rs != '0)) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && ent[k].v && (ent[k].rd == rs)) begin
                    found   = 1'b1;
                    hzd[k]  = 1'b1;
                    not_rdy = (ent[k].rdy != '0);
                end
            end
        end
    end

endmodule

// File: rtl/hzd_scoreboard.sv
// Register-write scoreboard: forwarding select and load-use stall for ID (HZD_PERF_EN adds counters).
// Latency: outputs combinational from entries and ID inputs; entries shift once per unheld cycle.
// Backpressure: stall holds ID; hold freezes every entry and counter.
module hzd_scoreboard
    import hzd_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int MAX_LAT = 1,
    parameter int LAT_W   = LAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_use,
    input  logic              id_rs2_use,
    input  logic              id_rw,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
`ifdef HZD_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt,
`endif
    output logic [DEPTH-1:0]  rs1_hzd,
    output logic [DEPTH-1:0]  rs2_hzd
);

    localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);

    hzd_entry_t ent [DEPTH];
    logic       rs1_not_rdy;
    logic       rs2_not_rdy;
    logic       issue;
    logic       issue_wr;

    hzd_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .src_use (id_rs1_use),
        .rs      (id_rs1),
        .ent     (ent),
        .hzd     (rs1_hzd),
        .not_rdy (rs1_not_rdy)
    );

    hzd_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .src_use (id_rs2_use),
        .rs      (id_rs2),
        .ent     (ent),
        .hzd     (rs2_hzd),
        .not_rdy (rs2_not_rdy)
    );

    assign stall    = id_valid & (rs1_not_rdy | rs2_not_rdy);
    assign issue    = id_valid & ~stall & ~flush;
    assign issue_wr = issue & id_rw & (id_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent[k] <= '0;
            end
        end else if (!hold) begin
            if (issue_wr) begin
                ent[0] <= '{v: 1'b1, rd: id_rd, rdy: lat_t'(id_lat)};
            end else begin
                ent[0] <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                ent[k].v   <= ent[k-1].v;
                ent[k].rd  <= ent[k-1].rd;
                ent[k].rdy <= (ent[k-1].rdy == '0) ? '0 : ent[k-1].rdy - 1'b1;
            end
        end
    end

`ifdef HZD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else if (!hold) begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (issue && ((rs1_hzd != '0) || (rs2_hzd != '0))) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`endif

    // A result latency beyond what the pipe depth can cover is a decode bug.
    a_lat_legal : assert property (@(posedge clk) disable iff (!rst_n)
        (id_valid && id_rw) |-> (id_lat <= MAX_LAT_L))
        else $error("hzd_scoreboard: id_lat %0d exceeds MAX_LAT %0d", id_lat, MAX_LAT);

endmodule
